// File: rtl/quadgen.sv
// Quadrature waveform generator: turns signed step commands into Gray-coded A/B edges
// at a programmable period. Define QUADGEN_INDEX_EN to add the once-per-revolution `z` output.
module quadgen #(
    parameter int PERIOD_W    = 16,
    parameter int STEPS_W     = 16,
    parameter int INDEX_EDGES = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [STEPS_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] period,
    input  logic                abort,
    output logic                a,
    output logic                b,
    output logic                busy,
    output logic                done,
`ifdef QUADGEN_INDEX_EN
    output logic                z,
`endif
    output logic [31:0]         position
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [PERIOD_W-1:0] PER_ZERO = '0;
    localparam logic [PERIOD_W-1:0] PER_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [STEPS_W:0]    REM_ONE  = {{STEPS_W{1'b0}}, 1'b1};
    localparam logic [STEPS_W-1:0]  STEPS_ZERO = '0;

    logic [0:0]          state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic [31:0]         pos_q, pos_d;
    logic [STEPS_W:0]    rem_q, rem_d;
    logic                dir_q, dir_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic [PERIOD_W-1:0] reload_q, reload_d;
    logic                done_q, done_d;
    logic                a_q, b_q;
    logic                edge_fire;

    logic [STEPS_W:0]    steps_ext;
    logic [PERIOD_W-1:0] per_eff;

    // Sign-extend one bit wider so the most negative command still has a representable magnitude.
    assign steps_ext = {cmd_steps[STEPS_W-1], cmd_steps};
    assign per_eff   = (period == PER_ZERO) ? PER_ONE : period;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        pos_d     = pos_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        timer_d   = timer_q;
        reload_d  = reload_q;
        done_d    = 1'b0;
        edge_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_steps == STEPS_ZERO) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = S_RUN;
                        rem_d    = cmd_steps[STEPS_W-1] ? (~steps_ext + REM_ONE) : steps_ext;
                        dir_d    = cmd_steps[STEPS_W-1];
                        timer_d  = per_eff - PER_ONE;
                        reload_d = per_eff - PER_ONE;
                    end
                end
            end
            default: begin
                // Abort wins over a pending edge so the waveform freezes where it is.
                if (abort) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (timer_q == PER_ZERO) begin
                    edge_fire = 1'b1;
                    phase_d   = dir_q ? (phase_q - 2'd1) : (phase_q + 2'd1);
                    pos_d     = dir_q ? (pos_q - 32'd1) : (pos_q + 32'd1);
                    rem_d     = rem_q - REM_ONE;
                    timer_d   = reload_q;
                    if (rem_q == REM_ONE) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - PER_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            phase_q  <= 2'd0;
            pos_q    <= 32'd0;
            rem_q    <= '0;
            dir_q    <= 1'b0;
            timer_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            pos_q    <= pos_d;
            rem_q    <= rem_d;
            dir_q    <= dir_d;
            timer_q  <= timer_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            a_q      <= phase_d[1] ^ phase_d[0];
            b_q      <= phase_d[1];
        end
    end

`ifdef QUADGEN_INDEX_EN
    localparam int REV_W = (INDEX_EDGES > 2) ? $clog2(INDEX_EDGES) : 1;
    localparam logic [REV_W-1:0] REV_MAX  = REV_W'(INDEX_EDGES - 1);
    localparam logic [REV_W-1:0] REV_ZERO = '0;
    localparam logic [REV_W-1:0] REV_ONE  = {{(REV_W-1){1'b0}}, 1'b1};

    logic [REV_W-1:0] rev_q, rev_d;
    logic             z_q;

    always_comb begin
        rev_d = rev_q;
        if (edge_fire) begin
            if (dir_q) begin
                rev_d = (rev_q == REV_ZERO) ? REV_MAX : (rev_q - REV_ONE);
            end else begin
                rev_d = (rev_q == REV_MAX) ? REV_ZERO : (rev_q + REV_ONE);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rev_q <= '0;
            z_q   <= 1'b1;
        end else begin
            rev_q <= rev_d;
            z_q   <= (rev_d == REV_ZERO);
        end
    end

    assign z = z_q;
`endif

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign a         = a_q;
    assign b         = b_q;
    assign position  = pos_q;

endmodule

// File: tb/tb_quadgen.sv
// Bench for quadgen: drives step commands and compares A/B, position, busy, done and
// cmd_ready every clock against an edge-schedule model of the generator.
module tb_quadgen;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic [15:0] period;
    logic        abort;
    logic        a;
    logic        b;
    logic        busy;
    logic        done;
    logic [31:0] position;

    int checks = 0;
    int errors = 0;

    // Model: waveform position in the forward AB cycle 00,10,11,01 and the edge count.
    logic [1:0] seq_ab [4];
    int         m_ph;
    int         m_pos;

    quadgen dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_steps (cmd_steps),
        .period    (period),
        .abort     (abort),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .position  (position)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one command (or completes one already presented) and follows it to its done pulse.
    task automatic run_cmd(input int steps, input int per, input int abort_at,
                           input bit preloaded, input bit chain,
                           input int nsteps, input int nper);
        int p;
        int n;
        int k;
        int c;
        bit fin;
        logic exp_busy;
        logic exp_done;
        logic [31:0] exp_pos;
        p = (per == 0) ? 1 : per;
        n = (steps < 0) ? -steps : steps;
        if (!preloaded) begin
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL ready_before_accept got %b want 1", cmd_ready);
            end
            cmd_valid = 1'b1;
            cmd_steps = 16'(steps);
            period    = 16'(per);
        end
        step();
        cmd_valid = 1'b0;
        exp_pos = 32'(m_pos);
        if (n == 0) begin
            checks++;
            if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", done); end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b want 0", busy); end
            checks++;
            if ({a, b} !== seq_ab[m_ph]) begin errors++; $display("FAIL zero_ab got %b want %b", {a, b}, seq_ab[m_ph]); end
            checks++;
            if (position !== exp_pos) begin errors++; $display("FAIL zero_pos got %0d want %0d", $signed(position), m_pos); end
            step();
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL zero_done_drop got %b want 0", done); end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_after got %b want 0", busy); end
            return;
        end
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL accept_busy got busy=%b ready=%b want busy=1 ready=0", busy, cmd_ready);
        end
        k = 0;
        c = 0;
        fin = 1'b0;
        while (!fin) begin
            cmd_steps = 16'($urandom);
            period    = 16'($urandom);
            if (abort_at == c + 1) abort = 1'b1;
            step();
            c++;
            abort = 1'b0;
            exp_busy = 1'b1;
            exp_done = 1'b0;
            if (c == abort_at) begin
                fin = 1'b1;
                exp_busy = 1'b0;
                exp_done = 1'b1;
            end else if (c % p == 0) begin
                k++;
                m_pos = m_pos + ((steps > 0) ? 1 : -1);
                m_ph  = (m_ph + ((steps > 0) ? 1 : 3)) % 4;
                if (k == n) begin
                    fin = 1'b1;
                    exp_busy = 1'b0;
                    exp_done = 1'b1;
                end
            end
            exp_pos = 32'(m_pos);
            checks++;
            if ({a, b} !== seq_ab[m_ph]) begin
                errors++;
                $display("FAIL ab cycle %0d got %b want %b", c, {a, b}, seq_ab[m_ph]);
            end
            checks++;
            if (position !== exp_pos) begin
                errors++;
                $display("FAIL position cycle %0d got %0d want %0d", c, $signed(position), m_pos);
            end
            checks++;
            if (busy !== exp_busy || cmd_ready !== !exp_busy) begin
                errors++;
                $display("FAIL busy cycle %0d got busy=%b ready=%b want busy=%b", c, busy, cmd_ready, exp_busy);
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done cycle %0d got %b want %b", c, done, exp_done);
            end
        end
        if (chain) begin
            cmd_valid = 1'b1;
            cmd_steps = 16'(nsteps);
            period    = 16'(nper);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++;
        if ({a, b} !== 2'b00) begin errors++; $display("FAIL reset_ab got %b want 00", {a, b}); end
        checks++;
        if (position !== 32'd0) begin errors++; $display("FAIL reset_pos got %0d want 0", position); end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy, done); end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
        reset = 1'b1;
        m_ph  = 0;
        m_pos = 0;
        step();
    endtask

    task automatic test_forward();
        run_cmd(8, 3, -1, 1'b0, 1'b0, 0, 0);
        step();
    endtask

    task automatic test_reverse();
        run_cmd(-5, 1, -1, 1'b0, 1'b0, 0, 0);
        step();
    endtask

    task automatic test_zero();
        run_cmd(0, 4, -1, 1'b0, 1'b0, 0, 0);
        step();
    endtask

    task automatic test_abort();
        run_cmd(100, 10, 35, 1'b0, 1'b0, 0, 0);
        step();
        run_cmd(3, 2, -1, 1'b0, 1'b0, 0, 0);
        step();
    endtask

    task automatic test_back_to_back();
        run_cmd(-32768, 0, -1, 1'b0, 1'b1, 6, 2);
        run_cmd(6, 2, -1, 1'b1, 1'b1, -3, 1);
        run_cmd(-3, 1, -1, 1'b1, 1'b0, 0, 0);
        step();
    endtask

    task automatic test_random();
        int s;
        int p;
        int ab;
        for (int i = 0; i < 12; i++) begin
            s  = int'($urandom_range(0, 40)) - 20;
            p  = int'($urandom_range(0, 4));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : -1;
            run_cmd(s, p, ab, 1'b0, 1'b0, 0, 0);
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1;
        cmd_steps = 16'd50;
        period    = 16'd2;
        step();
        cmd_valid = 1'b0;
        repeat (7) step();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({a, b} !== 2'b00) begin errors++; $display("FAIL midreset_ab got %b want 00", {a, b}); end
        checks++;
        if (position !== 32'd0) begin errors++; $display("FAIL midreset_pos got %0d want 0", position); end
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state got busy=%b ready=%b want 0 1", busy, cmd_ready);
        end
        m_ph  = 0;
        m_pos = 0;
        step();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_discard got busy=%b done=%b want 0 0", busy, done);
        end
        run_cmd(-4, 1, -1, 1'b0, 1'b0, 0, 0);
        step();
    endtask

    initial begin
        seq_ab[0] = 2'b00;
        seq_ab[1] = 2'b10;
        seq_ab[2] = 2'b11;
        seq_ab[3] = 2'b01;
        m_ph      = 0;
        m_pos     = 0;
        cmd_valid = 1'b0;
        cmd_steps = '0;
        period    = '0;
        abort     = 1'b0;
        reset     = 1'b0;
        test_reset();
        test_forward();
        test_reverse();
        test_zero();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
